// File: rtl/sram_like_slave_if.sv
// sram_like_slave_if: request/response bundle between a CPU memory port
// (master) and the sram-like memory responder (slave).
interface sram_like_slave_if #(
  parameter int unsigned QD_LOG2 = 2
);
  logic             req;
  logic             wr;
  logic [1:0]       size;
  logic [3:0]       wstrb;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic             stall_i;
  logic             addr_ok;
  logic             data_ok;
  logic [31:0]      rdata;
  logic [QD_LOG2:0] outstanding;

  modport master (
    output req, wr, size, wstrb, addr, wdata, stall_i,
    input  addr_ok, data_ok, rdata, outstanding
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata, stall_i,
    output addr_ok, data_ok, rdata, outstanding
  );
endinterface

// File: rtl/sram_like_slave.sv
// sram_like_slave: in-order memory responder for the req/addr_ok/data_ok
// protocol. Accepted requests wait in a circular queue, each counting down a
// fixed latency; the head completes (and writes commit) once its count hits 0.
module sram_like_slave #(
  parameter int unsigned MEM_AW  = 10,
  parameter int unsigned QD_LOG2 = 2,
  parameter int unsigned LATENCY = 2
) (
  input logic              clk,
  input logic              reset,
  sram_like_slave_if.slave bus
);
  localparam int unsigned      QD       = 1 << QD_LOG2;
  localparam logic [QD_LOG2:0] FULL     = {1'b1, {QD_LOG2{1'b0}}};
  localparam logic [3:0]       CNT_INIT = 4'(LATENCY - 1);

  // Queue storage, one slot per outstanding request.
  logic [QD-1:0]             q_valid;
  logic [QD-1:0]             q_wr;
  logic [QD-1:0][1:0]        q_size;
  logic [QD-1:0][3:0]        q_wstrb;
  logic [QD-1:0][MEM_AW-1:0] q_idx;
  logic [QD-1:0][31:0]       q_wdata;
  logic [QD-1:0][3:0]        q_cnt;

  logic [QD_LOG2-1:0] head;
  logic [QD_LOG2-1:0] tail;
  logic [QD_LOG2:0]   count;

  logic [31:0] mem [1 << MEM_AW];

  logic addr_ok;
  logic accept;
  logic complete;
  logic unused_bits;

  // Fullness is judged on the registered count only, so a full queue never
  // accepts even while its head is completing.
  assign addr_ok  = !reset && !bus.stall_i && (count != FULL);
  assign accept   = bus.req && addr_ok;
  assign complete = !reset && q_valid[head] && (q_cnt[head] == 4'd0);

  assign bus.addr_ok     = addr_ok;
  assign bus.data_ok     = complete;
  assign bus.outstanding = count;
  assign bus.rdata       = (complete && !q_wr[head]) ? mem[q_idx[head]] : '0;

  // Access size and the non-index address bits travel with the request but
  // never influence storage.
  assign unused_bits = ^{q_size, bus.addr[31:MEM_AW+2], bus.addr[1:0]};

  // Queue bookkeeping: countdown, pop at head, push at tail, occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid <= '0;
      q_cnt   <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      for (int unsigned i = 0; i < QD; i++) begin
        if (q_valid[QD_LOG2'(i)] && q_cnt[QD_LOG2'(i)] != 4'd0)
          q_cnt[QD_LOG2'(i)] <= q_cnt[QD_LOG2'(i)] - 4'd1;
      end
      if (complete) begin
        q_valid[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      // The queue is never full on accept, so tail cannot alias a live
      // head slot; the push therefore overrides the countdown safely.
      if (accept) begin
        q_valid[tail] <= 1'b1;
        q_wr[tail]    <= bus.wr;
        q_size[tail]  <= bus.size;
        q_wstrb[tail] <= bus.wstrb;
        q_idx[tail]   <= bus.addr[MEM_AW+1:2];
        q_wdata[tail] <= bus.wdata;
        q_cnt[tail]   <= CNT_INIT;
        tail          <= tail + 1'b1;
      end
      case ({accept, complete})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Byte-lane write commit when a write reaches the head and completes.
  always_ff @(posedge clk) begin
    if (complete && q_wr[head]) begin
      if (q_wstrb[head][0]) mem[q_idx[head]][7:0]   <= q_wdata[head][7:0];
      if (q_wstrb[head][1]) mem[q_idx[head]][15:8]  <= q_wdata[head][15:8];
      if (q_wstrb[head][2]) mem[q_idx[head]][23:16] <= q_wdata[head][23:16];
      if (q_wstrb[head][3]) mem[q_idx[head]][31:24] <= q_wdata[head][31:24];
    end
  end
endmodule

// File: tb/tb_sram_like_slave.sv
// tb_sram_like_slave: directed vectors against three responders that differ
// only in LATENCY (2, 8, 4); one is selected at a time to receive requests.
module tb_sram_like_slave;
  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr, stall;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  int          sel;

  logic        addr_ok_s, data_ok_s;
  logic [31:0] rdata_s;
  logic [2:0]  outstanding_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_like_slave_if #(.QD_LOG2(2)) if2 ();
  sram_like_slave_if #(.QD_LOG2(2)) if8 ();
  sram_like_slave_if #(.QD_LOG2(2)) if4 ();

  assign if2.req = req && (sel == 0);
  assign if8.req = req && (sel == 1);
  assign if4.req = req && (sel == 2);
  assign {if2.wr, if8.wr, if4.wr}                = {3{wr}};
  assign {if2.size, if8.size, if4.size}          = {3{2'd2}};
  assign {if2.wstrb, if8.wstrb, if4.wstrb}       = {3{wstrb}};
  assign {if2.addr, if8.addr, if4.addr}          = {3{addr}};
  assign {if2.wdata, if8.wdata, if4.wdata}       = {3{wdata}};
  assign {if2.stall_i, if8.stall_i, if4.stall_i} = {3{stall}};

  sram_like_slave #(.MEM_AW(10), .QD_LOG2(2), .LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .bus(if2));
  sram_like_slave #(.MEM_AW(10), .QD_LOG2(2), .LATENCY(8)) u_l8 (.clk(clk), .reset(reset), .bus(if8));
  sram_like_slave #(.MEM_AW(10), .QD_LOG2(2), .LATENCY(4)) u_l4 (.clk(clk), .reset(reset), .bus(if4));

  always_comb begin
    addr_ok_s = if4.addr_ok; data_ok_s = if4.data_ok; rdata_s = if4.rdata; outstanding_s = if4.outstanding;
    if (sel == 0) begin
      addr_ok_s = if2.addr_ok; data_ok_s = if2.data_ok; rdata_s = if2.rdata; outstanding_s = if2.outstanding;
    end else if (sel == 1) begin
      addr_ok_s = if8.addr_ok; data_ok_s = if8.data_ok; rdata_s = if8.rdata; outstanding_s = if8.outstanding;
    end
  end

  typedef struct {
    logic        rst, rq, w;
    logic [3:0]  st;
    logic [31:0] a, d;
    logic        stl;
    logic        e_aok, e_dok;
    logic [31:0] e_rd;
    logic [2:0]  e_out;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(logic rst, logic rq, logic w, logic [3:0] st, logic [31:0] a,
                             logic [31:0] d, logic stl, logic aok, logic dok,
                             logic [31:0] rd, logic [2:0] o);
    vec_t x;
    x.rst = rst; x.rq = rq; x.w = w; x.st = st; x.a = a; x.d = d; x.stl = stl;
    x.e_aok = aok; x.e_dok = dok; x.e_rd = rd; x.e_out = o;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Burst recording
  int          acc_cyc[16];
  int          first_dok;
  logic [31:0] rds[$];
  logic        aok_log[300];
  logic [2:0]  out_log[300];
  logic        stall_log[300];
  int          ncyc;

  task automatic run_burst(input int n, input logic w, input logic [31:0] base,
                           input logic [31:0] dbase, input bit tog);
    int issued = 0;
    int cyc = 0;
    bit finished = 0;
    first_dok = -1;
    rds.delete();
    while (!finished && cyc < 300) begin
      @(posedge clk); #1;
      req   = (issued < n);
      wr    = w;
      wstrb = 4'hF;
      addr  = base + 32'(issued) * 32'd4;
      wdata = dbase + 32'(issued);
      stall = tog && (cyc % 2 == 1);
      @(negedge clk);
      if (data_ok_s) begin
        if (first_dok < 0) first_dok = cyc;
        rds.push_back(rdata_s);
      end
      aok_log[cyc]   = addr_ok_s;
      out_log[cyc]   = outstanding_s;
      stall_log[cyc] = stall;
      if (req && addr_ok_s) begin
        acc_cyc[issued] = cyc;
        issued++;
      end else if (issued == n && outstanding_s == 3'd0) begin
        finished = 1;
      end
      cyc++;
    end
    ncyc = cyc;
    req = 1'b0;
    stall = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: actual issued %0d outstanding %0d required all done", issued, outstanding_s);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dok_seen;
    int viol;
    reset = 1'b1; req = 1'b0; wr = 1'b0; stall = 1'b0; wstrb = '0; addr = '0; wdata = '0; sel = 0;
    repeat (2) @(posedge clk);

    // rst req wr strb addr wdata stall | addr_ok data_ok rdata outstanding
    vt.push_back(v(1,1,1,4'hF,32'h10,32'h0,0,        0,0,32'h0,3'd0));
    vt.push_back(v(1,1,1,4'hF,32'h10,32'h0,0,        0,0,32'h0,3'd0));
    vt.push_back(v(1,1,1,4'hF,32'h10,32'h0,0,        0,0,32'h0,3'd0));
    vt.push_back(v(0,1,1,4'hF,32'h10,32'hDEADBEEF,0, 1,0,32'h0,3'd0));
    vt.push_back(v(0,1,0,4'h0,32'h10,32'h0,0,        1,0,32'h0,3'd1));
    vt.push_back(v(0,0,0,4'h0,32'h0,32'h0,0,         1,1,32'h0,3'd2));
    vt.push_back(v(0,0,0,4'h0,32'h0,32'h0,0,         1,1,32'hDEADBEEF,3'd1));
    vt.push_back(v(0,0,0,4'h0,32'h0,32'h0,0,         1,0,32'h0,3'd0));
    vt.push_back(v(0,1,1,4'hF,32'h20,32'h11223344,0, 1,0,32'h0,3'd0));
    vt.push_back(v(0,1,1,4'h5,32'h20,32'hAABBCCDD,0, 1,0,32'h0,3'd1));
    vt.push_back(v(0,1,0,4'h0,32'h20,32'h0,0,        1,1,32'h0,3'd2));
    vt.push_back(v(0,0,0,4'h0,32'h0,32'h0,0,         1,1,32'h0,3'd2));
    vt.push_back(v(0,0,0,4'h0,32'h0,32'h0,0,         1,1,32'h11BB33DD,3'd1));
    vt.push_back(v(0,0,0,4'h0,32'h0,32'h0,0,         1,0,32'h0,3'd0));
    vt.push_back(v(0,1,0,4'h0,32'h10,32'h0,1,        0,0,32'h0,3'd0));
    vt.push_back(v(0,1,0,4'h0,32'h10,32'h0,0,        1,0,32'h0,3'd0));
    vt.push_back(v(0,0,0,4'h0,32'h0,32'h0,0,         1,0,32'h0,3'd1));
    vt.push_back(v(0,0,0,4'h0,32'h0,32'h0,1,         0,1,32'hDEADBEEF,3'd1));
    vt.push_back(v(0,1,1,4'h0,32'h10,32'hFFFFFFFF,0, 1,0,32'h0,3'd0));
    vt.push_back(v(0,1,0,4'h0,32'h10,32'h0,0,        1,0,32'h0,3'd1));
    vt.push_back(v(0,0,0,4'h0,32'h0,32'h0,0,         1,1,32'h0,3'd2));
    vt.push_back(v(0,0,0,4'h0,32'h0,32'h0,0,         1,1,32'hDEADBEEF,3'd1));
    vt.push_back(v(0,0,0,4'h0,32'h0,32'h0,0,         1,0,32'h0,3'd0));

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk); #1;
      reset = vt[i].rst; req = vt[i].rq; wr = vt[i].w; wstrb = vt[i].st;
      addr = vt[i].a; wdata = vt[i].d; stall = vt[i].stl;
      @(negedge clk);
      chk($sformatf("vec%0d_addr_ok", i), {31'b0, addr_ok_s}, {31'b0, vt[i].e_aok});
      chk($sformatf("vec%0d_data_ok", i), {31'b0, data_ok_s}, {31'b0, vt[i].e_dok});
      chk($sformatf("vec%0d_rdata", i), rdata_s, vt[i].e_rd);
      chk($sformatf("vec%0d_outstanding", i), {29'b0, outstanding_s}, {29'b0, vt[i].e_out});
    end
    @(posedge clk); #1;
    req = 1'b0; stall = 1'b0;

    // Full queue with LATENCY 8: preload, then 6 back-to-back reads.
    sel = 1;
    run_burst(6, 1'b1, 32'h80, 32'h100, 1'b0);
    chk("full_preload_count", 32'(rds.size()), 32'd6);
    run_burst(6, 1'b0, 32'h80, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("full_accept%0d_cycle", i), 32'(acc_cyc[i]), 32'(i));
    chk("full_addr_ok_at_4", {31'b0, aok_log[4]}, 32'd0);
    chk("full_outstanding_at_4", {29'b0, out_log[4]}, 32'd4);
    chk("full_first_data_ok", 32'(first_dok), 32'd8);
    chk("full_accept5_cycle", 32'(acc_cyc[4]), 32'(first_dok + 1));
    chk("full_accept6_cycle", 32'(acc_cyc[5]), 32'(first_dok + 2));
    chk("full_data_ok_count", 32'(rds.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("full_rdata%0d", i), rds[i], 32'h100 + 32'(i));

    // Back-pressure and wrap-around with LATENCY 2.
    sel = 0;
    run_burst(10, 1'b1, 32'h0, 32'h0, 1'b0);
    run_burst(10, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("bp_data_ok_count", 32'(rds.size()), 32'd10);
    for (int i = 0; i < 10; i++) chk($sformatf("bp_rdata%0d", i), rds[i], 32'(i));
    viol = 0;
    for (int c = 0; c < ncyc; c++) if (stall_log[c] && aok_log[c]) viol++;
    chk("bp_addr_ok_while_stalled", 32'(viol), 32'd0);
    @(negedge clk);
    chk("bp_outstanding_end", {29'b0, outstanding_s}, 32'd0);

    // Reset mid-operation with LATENCY 4.
    sel = 2;
    run_burst(3, 1'b1, 32'hC0, 32'hA0, 1'b0);
    dok_seen = 0;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      req = (c < 3); wr = 1'b1; wstrb = 4'hF;
      addr = 32'hC0 + 32'(c) * 32'd4; wdata = 32'hB0 + 32'(c);
      reset = (c == 3 || c == 4);
      @(negedge clk);
      if (data_ok_s) dok_seen++;
      if (c < 3) chk($sformatf("rst_mid_accept%0d", c), {31'b0, addr_ok_s}, 32'd1);
    end
    req = 1'b0;
    chk("rst_mid_no_data_ok", 32'(dok_seen), 32'd0);
    chk("rst_mid_outstanding", {29'b0, outstanding_s}, 32'd0);
    run_burst(3, 1'b0, 32'hC0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) chk($sformatf("rst_mid_rdata%0d", i), rds[i], 32'hA0 + 32'(i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
